// File: rtl/game_pkg.sv
// Shared types and constants for the penalty-shootout game controller.
package game_pkg;

  // Game phases; the encoding is what appears on game_state.
  typedef enum logic [2:0] {
    START   = 3'd0,
    KEEPER  = 3'd1,
    SHOOTER = 3'd2,
    WINNER  = 3'd3,
    LOOSER  = 3'd4
  } g_state;

  typedef enum logic {
    SOLO  = 1'b0,
    MULTI = 1'b1
  } g_mode;

  localparam int DEFAULT_ROUNDS        = 5;
  localparam int DEFAULT_RESULT_FRAMES = 180;

  // Ceiling of every 4-bit tally shown to the player.
  localparam logic [3:0] CNT_MAX = 4'd15;

  // Conditional increment that sticks at CNT_MAX instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic inc);
    if (inc && (value != CNT_MAX)) begin
      return value + 4'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/control_if.sv
// Bundle of game status fields consumed by the display/sound logic.
interface control_if;
  logic [2:0] game_state;
  logic       game_mode;
  logic [3:0] score;
  logic [3:0] round_counter;
  logic       is_scored;

  modport out (
    output game_state,
    output game_mode,
    output score,
    output round_counter,
    output is_scored
  );

  modport in (
    input game_state,
    input game_mode,
    input score,
    input round_counter,
    input is_scored
  );
endinterface

// File: rtl/game_fsm_result_timer.sv
// Counts video frames while a result screen is shown; done flags the
// tick that completes the hold period so the FSM can leave on that edge.
module result_timer #(
  parameter int FRAMES = 180
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic done
);

  localparam int              W    = $clog2(FRAMES + 1);
  localparam logic [W-1:0]    LAST = W'(FRAMES - 1);
  localparam logic [W-1:0]    FULL = W'(FRAMES);

  logic [W-1:0] r_count;

  // Frame counter: cleared while idle, saturates at the hold length.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (tick && (r_count < FULL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign done = tick && (r_count >= LAST);

endmodule

// File: rtl/game_fsm.sv
// Penalty-shootout game controller: alternates player and opponent kicks,
// keeps the tallies, picks the winner and holds the result screen.
module game_fsm
  import game_pkg::*;
#(
  parameter int ROUNDS        = DEFAULT_ROUNDS,
  parameter int RESULT_FRAMES = DEFAULT_RESULT_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       mode_sel,
  input  logic       shot_done,
  input  logic       goal,
  input  logic       frame_tick,
  control_if.out     out_control
);

  localparam logic [2:0] ST_START   = START;
  localparam logic [2:0] ST_KEEPER  = KEEPER;
  localparam logic [2:0] ST_SHOOTER = SHOOTER;
  localparam logic [2:0] ST_WINNER  = WINNER;
  localparam logic [2:0] ST_LOOSER  = LOOSER;

  logic [2:0] r_state;
  logic       r_mode;
  logic [3:0] r_score;
  logic [3:0] r_opp;
  logic [3:0] r_rc;
  logic       r_scored;

  logic [2:0] w_state_next;
  logic       w_mode_next;
  logic [3:0] w_score_next;
  logic [3:0] w_opp_next;
  logic [3:0] w_rc_next;
  logic       w_scored_next;

  logic [3:0] w_rc_inc;
  logic [3:0] w_opp_inc;
  logic       w_in_result;
  logic       w_timer_done;

  assign w_rc_inc    = sat_inc(r_rc, 1'b1);
  assign w_opp_inc   = sat_inc(r_opp, goal);
  assign w_in_result = (r_state == ST_WINNER) || (r_state == ST_LOOSER);

  // Held in clear outside the result screens, so it starts from zero on entry.
  result_timer #(
    .FRAMES (RESULT_FRAMES)
  ) u_result_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (!w_in_result),
    .tick  (frame_tick),
    .done  (w_timer_done)
  );

  // Next-state and next-tally decode for one input cycle.
  always_comb begin
    w_state_next  = r_state;
    w_mode_next   = r_mode;
    w_score_next  = r_score;
    w_opp_next    = r_opp;
    w_rc_next     = r_rc;
    w_scored_next = r_scored;

    case (r_state)
      ST_START: begin
        // start_btn wins over a stray shot_done in the same cycle.
        if (start_btn) begin
          w_state_next  = ST_SHOOTER;
          w_mode_next   = mode_sel;
          w_score_next  = 4'd0;
          w_opp_next    = 4'd0;
          w_rc_next     = 4'd0;
          w_scored_next = 1'b0;
        end
      end

      ST_SHOOTER: begin
        if (shot_done) begin
          w_scored_next = goal;
          w_score_next  = sat_inc(r_score, goal);
          w_state_next  = ST_KEEPER;
        end
      end

      ST_KEEPER: begin
        if (shot_done) begin
          w_scored_next = goal;
          w_opp_next    = w_opp_inc;
          w_rc_next     = w_rc_inc;
          if (int'(w_rc_inc) < ROUNDS) begin
            w_state_next = ST_SHOOTER;
          end else if (r_score > w_opp_inc) begin
            w_state_next = ST_WINNER;
          end else if (r_score < w_opp_inc) begin
            w_state_next = ST_LOOSER;
          end else if (w_rc_inc == CNT_MAX) begin
            // Round tally can go no higher, so sudden death ends here.
            w_state_next = ST_LOOSER;
          end else begin
            w_state_next = ST_SHOOTER;
          end
        end
      end

      ST_WINNER, ST_LOOSER: begin
        // Tallies and mode stay untouched so the display keeps showing them.
        if (start_btn || w_timer_done) begin
          w_state_next = ST_START;
        end
      end

      default: begin
        w_state_next = ST_START;
      end
    endcase
  end

  // Status registers; reset aborts any game straight back to START.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_START;
      r_mode   <= MULTI;
      r_score  <= 4'd0;
      r_opp    <= 4'd0;
      r_rc     <= 4'd0;
      r_scored <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_mode   <= w_mode_next;
      r_score  <= w_score_next;
      r_opp    <= w_opp_next;
      r_rc     <= w_rc_next;
      r_scored <= w_scored_next;
    end
  end

  assign out_control.game_state    = r_state;
  assign out_control.game_mode     = r_mode;
  assign out_control.score         = r_score;
  assign out_control.round_counter = r_rc;
  assign out_control.is_scored     = r_scored;

endmodule

// File: tb/tb_game_fsm.sv
// Directed and randomized checks of game_fsm against a kick-tally model.
module tb_game_fsm;
  import game_pkg::*;

  localparam int ROUNDS = 5;
  localparam int FRAMES = 180;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_btn = 1'b0;
  logic mode_sel = 1'b0;
  logic shot_done = 1'b0;
  logic goal = 1'b0;
  logic frame_tick = 1'b0;

  control_if u_if ();

  game_fsm #(
    .ROUNDS        (ROUNDS),
    .RESULT_FRAMES (FRAMES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_btn   (start_btn),
    .mode_sel    (mode_sel),
    .shot_done   (shot_done),
    .goal        (goal),
    .frame_tick  (frame_tick),
    .out_control (u_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: raw kick and goal totals, result-screen frame count.
  g_state m_st = START;
  logic   m_mode = 1'b1;
  logic   m_sc = 1'b0;
  int     m_pgoals = 0;
  int     m_ogoals = 0;
  int     m_okicks = 0;
  int     m_frames = 0;

  function automatic logic [3:0] cap15(input int v);
    return (v > 15) ? 4'd15 : 4'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit s, input bit ms, input bit sh, input bit g, input bit t);
    if (r) begin
      m_st = START; m_mode = 1'b1; m_sc = 1'b0;
      m_pgoals = 0; m_ogoals = 0; m_okicks = 0; m_frames = 0;
      return;
    end
    case (m_st)
      START: if (s) begin
        m_st = SHOOTER; m_mode = ms; m_sc = 1'b0;
        m_pgoals = 0; m_ogoals = 0; m_okicks = 0;
      end
      SHOOTER: if (sh) begin
        m_pgoals += int'(g); m_sc = g; m_st = KEEPER;
      end
      KEEPER: if (sh) begin
        m_ogoals += int'(g); m_okicks++; m_sc = g; m_frames = 0;
        if (m_okicks < ROUNDS)          m_st = SHOOTER;
        else if (m_pgoals > m_ogoals)   m_st = WINNER;
        else if (m_pgoals < m_ogoals)   m_st = LOOSER;
        else if (m_okicks >= 15)        m_st = LOOSER;
        else                            m_st = SHOOTER;
      end
      default: begin
        if (s) m_st = START;
        else if (t) begin
          m_frames++;
          if (m_frames == FRAMES) m_st = START;
        end
      end
    endcase
  endtask

  // One clock cycle: drive, advance model, compare every output field.
  task automatic cyc(input string tag, input bit r, input bit s, input bit ms,
                     input bit sh, input bit g, input bit t);
    rst = r; start_btn = s; mode_sel = ms; shot_done = sh; goal = g; frame_tick = t;
    model(r, s, ms, sh, g, t);
    @(posedge clk);
    #1;
    rst = 0; start_btn = 0; mode_sel = 0; shot_done = 0; goal = 0; frame_tick = 0;
    chk({tag, ".state"}, 32'(u_if.game_state), 32'(m_st));
    chk({tag, ".mode"},  32'(u_if.game_mode), 32'(m_mode));
    chk({tag, ".score"}, 32'(u_if.score), 32'(cap15(m_pgoals)));
    chk({tag, ".round"}, 32'(u_if.round_counter), 32'(cap15(m_okicks)));
    chk({tag, ".scored"}, 32'(u_if.is_scored), 32'(m_sc));
  endtask

  // One round: player kick, a noisy idle cycle, opponent kick.
  task automatic play_round(input string tag, input bit pg, input bit og);
    cyc({tag, ".kick"}, 0, 0, 0, 1, pg, 0);
    cyc({tag, ".noise"}, 0, 1, 1, 0, ~pg, 1);
    cyc({tag, ".save"}, 0, 0, 0, 1, og, 0);
  endtask

  initial begin
    bit pg, og;
    int guard;

    cyc("reset0", 1, 0, 0, 0, 0, 0);
    cyc("reset1", 1, 0, 0, 1, 1, 1);
    chk("reset_state", 32'(u_if.game_state), 32'(START));
    chk("reset_mode", 32'(u_if.game_mode), 32'(MULTI));

    // Solo start.
    cyc("start_solo", 0, 1, 0, 0, 0, 0);
    chk("solo_state", 32'(u_if.game_state), 32'(SHOOTER));
    chk("solo_mode", 32'(u_if.game_mode), 32'(SOLO));

    // start_btn ignored in SHOOTER alongside a goal.
    cyc("start_in_shooter", 0, 1, 1, 1, 1, 0);
    chk("sis_state", 32'(u_if.game_state), 32'(KEEPER));
    chk("sis_score", 32'(u_if.score), 32'd1);
    cyc("keeper1", 0, 0, 0, 1, 1, 0);
    cyc("shooter2", 0, 0, 0, 1, 1, 0);
    chk("pre_rst_score", 32'(u_if.score), 32'd2);

    // Reset in KEEPER aborts the game.
    cyc("rst_keeper", 1, 0, 0, 0, 0, 0);
    chk("rst_state", 32'(u_if.game_state), 32'(START));
    chk("rst_score", 32'(u_if.score), 32'd0);
    chk("rst_mode", 32'(u_if.game_mode), 32'(MULTI));
    chk("rst_scored", 32'(u_if.is_scored), 32'd0);
    cyc("shot_in_start", 0, 0, 0, 1, 1, 0);

    // Clean sheet win.
    cyc("start_multi", 0, 1, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) play_round("sweep", 1, 0);
    chk("sweep_state", 32'(u_if.game_state), 32'(WINNER));
    chk("sweep_score", 32'(u_if.score), 32'd5);
    chk("sweep_round", 32'(u_if.round_counter), 32'd5);
    cyc("shot_in_winner", 0, 0, 0, 1, 1, 0);

    // Full result hold.
    for (int i = 0; i < FRAMES - 1; i++) cyc("hold", 0, 0, 0, 0, 0, 1);
    chk("hold_179", 32'(u_if.game_state), 32'(WINNER));
    cyc("hold_last", 0, 0, 0, 0, 0, 1);
    chk("expire_state", 32'(u_if.game_state), 32'(START));
    chk("expire_score", 32'(u_if.score), 32'd5);
    chk("expire_round", 32'(u_if.round_counter), 32'd5);

    // 3-3 tie into sudden death, won in round 6.
    cyc("start_tie", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) play_round("tie", (i < 3), (i < 3));
    chk("tie_state", 32'(u_if.game_state), 32'(SHOOTER));
    chk("tie_round", 32'(u_if.round_counter), 32'd5);
    play_round("sd", 1, 0);
    chk("sd_state", 32'(u_if.game_state), 32'(WINNER));
    chk("sd_round", 32'(u_if.round_counter), 32'd6);

    // Early exit with start_btn on tick 10.
    for (int i = 0; i < 9; i++) cyc("early", 0, 0, 0, 0, 0, 1);
    cyc("early_btn", 0, 1, 1, 0, 0, 1);
    chk("early_state", 32'(u_if.game_state), 32'(START));
    cyc("early_after", 0, 0, 0, 0, 0, 1);

    // Loss, then start_btn coinciding with expiry.
    cyc("start_loss", 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) play_round("loss", 0, 1);
    chk("loss_state", 32'(u_if.game_state), 32'(LOOSER));
    for (int i = 0; i < FRAMES - 1; i++) cyc("lhold", 0, 0, 0, 0, 0, 1);
    cyc("both_exit", 0, 1, 0, 0, 0, 1);
    chk("both_state", 32'(u_if.game_state), 32'(START));
    cyc("both_after", 0, 0, 0, 0, 0, 0);
    chk("both_after_state", 32'(u_if.game_state), 32'(START));

    // Endless ties until the round tally tops out.
    cyc("start_sat", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) play_round("sat", 1, 1);
    chk("sat_state", 32'(u_if.game_state), 32'(LOOSER));
    chk("sat_score", 32'(u_if.score), 32'd15);
    chk("sat_round", 32'(u_if.round_counter), 32'd15);
    cyc("sat_exit", 0, 1, 0, 0, 0, 0);

    // Random games.
    for (int gm = 0; gm < 20; gm++) begin
      cyc("rnd_start", 0, 1, 1'($urandom_range(1)), 0, 0, 0);
      guard = 0;
      while (m_st != START && guard < 3000) begin
        if (m_st == SHOOTER || m_st == KEEPER) begin
          pg = 1'($urandom_range(1));
          og = ($urandom_range(3) == 0);
          cyc("rnd_play", 0, og, pg, og, pg, 1'($urandom_range(1)));
        end else begin
          cyc("rnd_result", 0, ($urandom_range(150) == 0), 0,
              1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        guard++;
      end
      chk("rnd_bound", 32'(guard < 3000), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
